// File: rtl/nic_pkg.sv
// Shared constants for the processor-side register map and ring-side packet fields.
// Status bits use processor numbering; the VC bit uses network numbering.
package nic_pkg;

    localparam int DATA_W = 64;

    localparam logic [1:0] RECV_DATA = 2'd0;
    localparam logic [1:0] RECV_STAT = 2'd1;
    localparam logic [1:0] SEND_DATA = 2'd2;
    localparam logic [1:0] SEND_STAT = 2'd3;

    localparam int STAT_BIT = 63;
    localparam int VC_BIT   = 63;

endpackage

// File: rtl/fifo_nic_if.sv
// Processor register port and ring handshake of one NIC, bundled as an interface.
// Processor buses are [0:63]; ring buses are [63:0].
interface fifo_nic_if;

    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicEnWr;

    logic        net_si;
    logic        net_ro;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ri;
    logic [63:0] net_do;
    logic        net_polarity;

    modport master (
        output addr, d_in, nicEn, nicEnWr,
        output net_si, net_di, net_ri, net_polarity,
        input  d_out, net_ro, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicEnWr,
        input  net_si, net_di, net_ri, net_polarity,
        output d_out, net_ro, net_so, net_do
    );

endinterface

// File: rtl/nic_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count that alone defines full/empty.
// Push while full and pop while empty are ignored.
module nic_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/fifo_nic.sv
// NIC between a processor register port and a ring stop, with send and receive FIFOs.
// Holds register decode, the registered read-data port and VC polarity gating.
module fifo_nic
    import nic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       reset,
    fifo_nic_if.slave nic
);

    logic [DATA_W-1:0] recv_head, send_head;
    logic              recv_full, recv_empty;
    logic              send_full, send_empty;
    logic [PTR_W:0]    recv_count, send_count;
    logic              recv_push, recv_pop;
    logic              send_push, send_pop;
    logic              rd_en, wr_en;
    logic [0:DATA_W-1] d_out_q, d_out_d;
    logic              unused_cnt;

    assign rd_en = nic.nicEn & ~nic.nicEnWr;
    assign wr_en = nic.nicEn & nic.nicEnWr;

    assign recv_push = nic.net_si & ~recv_full;
    assign recv_pop  = rd_en & (nic.addr == RECV_DATA) & ~recv_empty;
    assign send_push = wr_en & (nic.addr == SEND_DATA) & ~send_full;
    // A head on the ring's current VC phase blocks everything behind it.
    assign send_pop  = ~send_empty & nic.net_ri & (send_head[VC_BIT] != nic.net_polarity);

    assign nic.net_ro = ~recv_full;
    assign nic.net_so = send_pop;
    assign nic.net_do = send_head;
    assign nic.d_out  = d_out_q;

    assign unused_cnt = ^{recv_count, send_count};

    nic_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W), .PTR_W(PTR_W)) u_recv_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (recv_push),
        .pop_i   (recv_pop),
        .din_i   (nic.net_di),
        .dout_o  (recv_head),
        .full_o  (recv_full),
        .empty_o (recv_empty),
        .count_o (recv_count)
    );

    nic_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W), .PTR_W(PTR_W)) u_send_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (send_push),
        .pop_i   (send_pop),
        .din_i   (nic.d_in),
        .dout_o  (send_head),
        .full_o  (send_full),
        .empty_o (send_empty),
        .count_o (send_count)
    );

    // Vector assignment between [63:0] and [0:63] gives the d[i] <-> net[63-i] mapping.
    always_comb begin
        d_out_d = d_out_q;
        if (rd_en) begin
            d_out_d = '0;
            unique case (nic.addr)
                RECV_DATA: if (!recv_empty) d_out_d = recv_head;
                RECV_STAT: d_out_d[STAT_BIT] = ~recv_empty;
                SEND_STAT: d_out_d[STAT_BIT] = send_full;
                default:   d_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) d_out_q <= '0;
        else        d_out_q <= d_out_d;
    end

endmodule

// File: tb/tb_fifo_nic.sv
// Directed and random stimulus for fifo_nic, checked every cycle against a queue model.
module tb_fifo_nic;
    import nic_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    fifo_nic_if nif();

    fifo_nic #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .nic   (nif)
    );

    always #5 clk = ~clk;

    logic [63:0] rq[$];
    logic [63:0] sq[$];
    logic [63:0] sent_log[$];
    logic [63:0] exp_dout = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        nif.nicEn = 1'b0;
        nif.nicEnWr = 1'b0;
        nif.addr = 2'd0;
        nif.d_in = '0;
        nif.net_si = 1'b0;
        nif.net_di = '0;
    endtask

    // One clock: check ring outputs mid-cycle, advance the model, check d_out after the edge.
    task automatic cycle();
        bit          s_pop, r_full, s_full;
        logic [63:0] h;
        @(negedge clk);
        n_vec++;
        chk("net_ro", {63'd0, nif.net_ro}, {63'd0, rq.size() != DEPTH});
        s_pop = 1'b0;
        if (sq.size() != 0) begin
            h = sq[0];
            s_pop = nif.net_ri && (h[VC_BIT] != nif.net_polarity);
            chk("net_do", nif.net_do, h);
        end
        chk("net_so", {63'd0, nif.net_so}, {63'd0, s_pop});
        r_full = (rq.size() == DEPTH);
        s_full = (sq.size() == DEPTH);
        if (nif.nicEn && !nif.nicEnWr) begin
            case (nif.addr)
                2'd0:    exp_dout = (rq.size() != 0) ? rq.pop_front() : 64'd0;
                2'd1:    exp_dout = (rq.size() != 0) ? 64'd1 : 64'd0;
                2'd3:    exp_dout = s_full ? 64'd1 : 64'd0;
                default: exp_dout = 64'd0;
            endcase
        end
        if (nif.net_si && !r_full) rq.push_back(nif.net_di);
        if (s_pop) sent_log.push_back(sq.pop_front());
        if (nif.nicEn && nif.nicEnWr && nif.addr == 2'd2 && !s_full) sq.push_back(nif.d_in);
        @(posedge clk);
        #1;
        chk("d_out", nif.d_out, exp_dout);
    endtask

    task automatic rd(input logic [1:0] a);
        nif.nicEn = 1'b1;
        nif.nicEnWr = 1'b0;
        nif.addr = a;
        cycle();
        nif.nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nif.nicEn = 1'b1;
        nif.nicEnWr = 1'b1;
        nif.addr = a;
        nif.d_in = d;
        cycle();
        nif.nicEn = 1'b0;
        nif.nicEnWr = 1'b0;
    endtask

    initial begin
        int mark;
        bit saw_dead;
        reset = 1'b0;
        idle();
        nif.net_ri = 1'b0;
        nif.net_polarity = 1'b0;
        #1;
        chk("rst_dout", nif.d_out, 64'd0);
        chk("rst_so", {63'd0, nif.net_so}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Status reads after reset
        rd(RECV_STAT);
        chk("stat_recv_rst", nif.d_out, 64'd0);
        rd(SEND_STAT);
        chk("stat_send_rst", nif.d_out, 64'd0);
        chk("ro_rst", {63'd0, nif.net_ro}, 64'd1);

        // Ring fills the receive FIFO, processor drains it in order
        for (int i = 0; i < 4; i++) begin
            nif.net_si = 1'b1;
            nif.net_di = 64'hA1 + 64'(i);
            cycle();
        end
        nif.net_si = 1'b0;
        chk("ro_full", {63'd0, nif.net_ro}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd(RECV_DATA);
            chk("rd_A", nif.d_out, 64'hA1 + 64'(i));
        end
        rd(RECV_DATA);
        chk("rd_empty", nif.d_out, 64'd0);
        rd(RECV_STAT);
        chk("stat_recv_empty", nif.d_out, 64'd0);

        // VC polarity gating
        nif.net_ri = 1'b1;
        nif.net_polarity = 1'b0;
        mark = sent_log.size();
        wr(SEND_DATA, 64'h8000_0000_0000_0011);
        for (int i = 0; i < 4; i++) begin
            nif.net_polarity = (i % 2 == 0);
            cycle();
        end
        chk("vc1_count", 64'(sent_log.size() - mark), 64'd1);
        if (sent_log.size() > mark) chk("vc1_data", sent_log[mark], 64'h8000_0000_0000_0011);
        nif.net_polarity = 1'b0;
        mark = sent_log.size();
        wr(SEND_DATA, 64'h0000_0000_0000_0022);
        for (int i = 0; i < 4; i++) begin
            nif.net_polarity = (i % 2 == 1);
            cycle();
        end
        chk("vc0_count", 64'(sent_log.size() - mark), 64'd1);

        // Send FIFO full, extra write dropped
        nif.net_ri = 1'b0;
        wr(SEND_DATA, 64'h8000_0000_0000_0031);
        wr(SEND_DATA, 64'h0000_0000_0000_0032);
        wr(SEND_DATA, 64'h8000_0000_0000_0033);
        wr(SEND_DATA, 64'h0000_0000_0000_0034);
        wr(SEND_DATA, 64'h0000_0000_0000_DEAD);
        rd(SEND_STAT);
        chk("stat_send_full", nif.d_out, 64'd1);
        mark = sent_log.size();
        nif.net_ri = 1'b1;
        for (int i = 0; i < 12; i++) begin
            nif.net_polarity = (i % 2 == 1);
            cycle();
        end
        chk("full_drain_count", 64'(sent_log.size() - mark), 64'd4);
        saw_dead = 1'b0;
        for (int i = mark; i < sent_log.size(); i++)
            if (sent_log[i] == 64'hDEAD) saw_dead = 1'b1;
        chk("dead_dropped", {63'd0, saw_dead}, 64'd0);

        // Full receive FIFO with a simultaneous processor pop
        for (int i = 0; i < 4; i++) begin
            nif.net_si = 1'b1;
            nif.net_di = 64'h10 + 64'(i);
            cycle();
        end
        nif.net_di = 64'h14;
        rd(RECV_DATA);
        chk("pop_full", nif.d_out, 64'h10);
        chk("ro_after_pop", {63'd0, nif.net_ro}, 64'd1);
        cycle();
        nif.net_si = 1'b0;
        chk("ro_refull", {63'd0, nif.net_ro}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            rd(RECV_DATA);
            chk("rd_order", nif.d_out, 64'h11 + 64'(i));
        end

        // Reset with three entries in each FIFO and a read in flight
        nif.net_ri = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nif.net_si = 1'b1;
            nif.net_di = 64'h21 + 64'(i);
            wr(SEND_DATA, (i % 2 == 0) ? (64'h8000_0000_0000_0041 + 64'(i)) : (64'h41 + 64'(i)));
        end
        nif.net_si = 1'b0;
        nif.net_ri = 1'b1;
        nif.net_polarity = 1'b0;
        nif.nicEn = 1'b1;
        nif.nicEnWr = 1'b0;
        nif.addr = RECV_DATA;
        @(negedge clk);
        n_vec++;
        chk("so_before_rst", {63'd0, nif.net_so}, 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("so_async_rst", {63'd0, nif.net_so}, 64'd0);
        chk("dout_async_rst", nif.d_out, 64'd0);
        @(posedge clk);
        #1;
        chk("dout_in_rst", nif.d_out, 64'd0);
        idle();
        @(posedge clk);
        #1 reset = 1'b1;
        n_vec++;
        rq.delete();
        sq.delete();
        exp_dout = '0;
        rd(RECV_STAT);
        chk("stat_recv_post", nif.d_out, 64'd0);
        rd(SEND_STAT);
        chk("stat_send_post", nif.d_out, 64'd0);
        mark = sent_log.size();
        wr(SEND_DATA, 64'h8000_0000_0000_0051);
        cycle();
        chk("post_rst_sent", 64'(sent_log.size() - mark), 64'd1);
        if (sent_log.size() > mark) chk("post_rst_data", sent_log[mark], 64'h8000_0000_0000_0051);
        nif.net_si = 1'b1;
        nif.net_di = 64'h61;
        cycle();
        nif.net_si = 1'b0;
        rd(RECV_DATA);
        chk("post_rst_recv", nif.d_out, 64'h61);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            nif.nicEn = ($urandom_range(0, 99) < 60);
            nif.nicEnWr = $urandom_range(0, 1);
            nif.addr = 2'($urandom_range(0, 3));
            nif.d_in = {$urandom, $urandom};
            nif.net_si = $urandom_range(0, 1);
            nif.net_di = {$urandom, $urandom};
            nif.net_ri = ($urandom_range(0, 99) < 70);
            nif.net_polarity = $urandom_range(0, 1);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_nic.md
Name: fifo_nic

Overview:
- Network interface between one gold_processor node and its ring stop in the 4-node CMP.
- Replaces the single-slot NIC buffering with DEPTH-entry send and receive FIFOs.
- Processor side: 2-bit memory-mapped register port.
- Ring side: valid/ready handshake plus even/odd virtual-channel polarity gating.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  [0:1]  register select: 0 = recv data, 1 = recv status, 2 = send data, 3 = send status.
- d_in  in  [0:63]  processor write data.
- d_out  out  [0:63]  registered processor read data.
- nicEn  in  1  register access strobe.
- nicEnWr  in  1  1 = write, 0 = read; valid only with nicEn.
- net_si  in  1  ring offers a packet to the NIC.
- net_ro  out  1  NIC can accept a packet.
- net_di  in  [63:0]  incoming packet.
- net_so  out  1  NIC offers a packet to the ring.
- net_ri  in  1  ring can accept a packet.
- net_do  out  [63:0]  outgoing packet.
- net_polarity  in  1  ring VC phase for this cycle.

Behaviour:
- Bit mapping: processor bit d_in[i] equals network bit [63-i]; no reordering of packet contents.
- Reset (reset=0, asynchronous): both FIFOs empty, pointers and counts 0, d_out=0, net_so=0. net_ro=1 after release.
- Receive path:
  - net_ro = (recv_count != DEPTH), taken from registered count.
  - net_si & net_ro at an edge pushes net_di.
  - net_si while net_ro=0 is ignored; the ring must hold the packet.
- Send path:
  - net_do = send FIFO head, combinational from storage.
  - net_so = send non-empty & net_ri & (head[63] != net_polarity).
  - A pop occurs on every edge where net_so=1.
  - A head whose VC bit matches net_polarity waits. No reordering behind it (FIFO order strict).
- Register reads (nicEn=1, nicEnWr=0) update d_out at the next edge; 1-cycle latency.
  - addr 0: head of recv FIFO; pops it. If empty, d_out=0 and no pop.
  - addr 1: d_out[63] = recv non-empty, other bits 0.
  - addr 2: d_out=0.
  - addr 3: d_out[63] = send full, other bits 0.
  - d_out holds its value when there is no read.
- Register writes (nicEn=1, nicEnWr=1):
  - addr 2 pushes d_in to send FIFO if not full.
  - A write to a full send FIFO is dropped silently; no state change.
  - Writes to addr 0/1/3 are ignored; d_out unchanged.
- Simultaneous events:
  - Push and pop on the same FIFO in one edge: both happen, count unchanged.
  - Pop of the last entry plus push: FIFO stays at count 1 with the new entry.
  - Full recv FIFO plus processor pop in the same cycle: net_ro stays 0 that cycle, no push; net_ro=1 next cycle.
- Pointer wrap: pointers wrap modulo DEPTH. Count is PTR_W+1 bits and is the sole source of full/empty.
- Reset mid-transfer: all FIFO contents discarded. net_so drops to 0 asynchronously. Any in-flight processor read returns 0.

Decomposition:
- Shared package nic_pkg:
  - register address constants RECV_DATA=0, RECV_STAT=1, SEND_DATA=2, SEND_STAT=3.
  - STAT_BIT=63.
  - VC_BIT=63 (network numbering).
- One sub-module nic_sync_fifo(DEPTH, width 64), instantiated twice (send, recv):
  - inputs push, pop, din.
  - outputs dout (head), full, empty, count.
  - async active-low reset.
- Top level holds register decode, d_out register and polarity gating.

Test Plan:
- Reset, then read addr 1 and addr 3 -> d_out=0 both times; net_ro=1, net_so=0.
- Ring pushes 0x0000_0000_0000_00A1..A4 with net_si=1 for 4 cycles -> net_ro=0 after 4th. Four addr-0 reads return A1,A2,A3,A4 in order. Fifth read returns 0; status bit 63 then 0.
- Processor writes 0x8000_0000_0000_0011 to addr 2 with net_ri=1, polarity toggling from 0:
  - net_so=1 only in polarity=0 cycles.
  - net_do=0x8000_0000_0000_0011, popped in one cycle.
  - A head with bit63=0 goes only when polarity=1.
- Fill send FIFO (4 writes, net_ri=0), fifth write 0xDEAD -> dropped; addr 3 reads bit63=1. Release net_ri -> exactly 4 packets emerge, none equal to 0xDEAD.
- Recv FIFO full, processor pops addr 0 while net_si=1 -> no push that cycle. Push accepted the next cycle; final count 4, order preserved.
- Assert reset for one cycle with 3 entries in each FIFO -> net_so=0 immediately; both status reads 0; later packets unaffected by old data.
